regfile_sequencer: RTL and testbench

Command-driven initiator for the 8 x 16-bit register file: it accepts one register-transfer command at a time and issues the `readnum` / `writenum` / `write` / `data_in` sequence that carries it out. It sits between the instruction controller and `regfile`, on the driving side of the regfile port. The regfile read (`data_out = R[readnum]`) is combinational; its write happens on the rising `clk` edge when `write = 1`.

---
 rtl/regfile_sequencer.sv | 122 ++++++++++++
 tb/tb_regfile_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for an 8 x 16-bit register file.
// It turns one MOVI/MOV/SWAP/PEEK command into a readnum/writenum/write/data_in sequence.
module regfile_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [1:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [7:0]  imm8,
    input  logic [15:0] rf_data_out,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [15:0] data_in,
    output logic        w,
    output logic [15:0] result
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_WR_IMM,
        ST_RD_A,
        ST_RD_B,
        ST_WR_A,
        ST_WR_B,
        ST_PEEK
    } state_t;

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    state_t      state, state_next;
    logic [1:0]  op_q;
    logic [2:0]  rd_q, rn_q;
    logic [7:0]  imm_q;
    logic [15:0] tmp_a, tmp_b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_WAIT;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            rd_q   <= '0;
            rn_q   <= '0;
            imm_q  <= '0;
            tmp_a  <= '0;
            tmp_b  <= '0;
            result <= '0;
        end else begin
            if (state == ST_WAIT && s) begin
                op_q  <= op;
                rd_q  <= rd;
                rn_q  <= rn;
                imm_q <= imm8;
            end
            if (state == ST_RD_A) tmp_a  <= rf_data_out;
            if (state == ST_RD_B) tmp_b  <= rf_data_out;
            if (state == ST_PEEK) result <= rf_data_out;
        end
    end

    // The command is dispatched from the live op in WAIT; later states follow op_q.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_WAIT: begin
                if (s) begin
                    unique case (op)
                        OP_MOVI: state_next = ST_WR_IMM;
                        OP_MOV:  state_next = ST_RD_A;
                        OP_SWAP: state_next = ST_RD_A;
                        OP_PEEK: state_next = ST_PEEK;
                        default: state_next = ST_WAIT;
                    endcase
                end
            end
            ST_WR_IMM: state_next = ST_WAIT;
            ST_RD_A:   state_next = (op_q == OP_SWAP) ? ST_RD_B : ST_WR_A;
            ST_RD_B:   state_next = ST_WR_A;
            ST_WR_A:   state_next = (op_q == OP_SWAP) ? ST_WR_B : ST_WAIT;
            ST_WR_B:   state_next = ST_WAIT;
            ST_PEEK:   state_next = ST_WAIT;
            default:   state_next = ST_WAIT;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w        = 1'b0;
        write    = 1'b0;
        readnum  = rn_q;
        writenum = rd_q;
        data_in  = tmp_a;
        unique case (state)
            ST_WAIT:   w = 1'b1;
            ST_WR_IMM: begin
                write   = 1'b1;
                data_in = {{8{imm_q[7]}}, imm_q};
            end
            ST_RD_A:   readnum = rn_q;
            ST_RD_B:   readnum = rd_q;
            ST_WR_A:   write = 1'b1;
            ST_WR_B: begin
                write    = 1'b1;
                writenum = rn_q;
                data_in  = tmp_b;
            end
            ST_PEEK:   readnum = rn_q;
            default:   w = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a simple regfile is attached, commands are issued,
// and register contents, busy/write counts and PEEK results are compared with a command-level model.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset, s;
    logic [1:0]  op;
    logic [2:0]  rd, rn;
    logic [7:0]  imm8;
    logic [15:0] rf_data_out, data_in, result;
    logic [2:0]  readnum, writenum;
    logic        write, w;

    always #5 clk = ~clk;

    regfile_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .op(op), .rd(rd), .rn(rn), .imm8(imm8),
        .rf_data_out(rf_data_out), .readnum(readnum), .writenum(writenum),
        .write(write), .data_in(data_in), .w(w), .result(result)
    );

    // Attached register file plus a backdoor port for preloading values.
    logic [15:0] rf [8];
    logic        bk_we;
    logic [2:0]  bk_idx;
    logic [15:0] bk_val;

    always @(posedge clk) begin
        if (write)      rf[writenum] <= data_in;
        else if (bk_we) rf[bk_idx]   <= bk_val;
    end
    assign rf_data_out = rf[readnum];

    // Command-level reference model.
    logic [15:0] m [8];
    logic [15:0] m_result;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_r%0d", tag, i), {16'h0, rf[i]}, {16'h0, m[i]});
    endtask

    task automatic poke(input logic [2:0] idx, input logic [15:0] val);
        bk_we  = 1'b1;
        bk_idx = idx;
        bk_val = val;
        m[idx] = val;
        @(negedge clk);
        bk_we  = 1'b0;
    endtask

    // Issue one command starting at a negedge with w == 1; returns at the first idle negedge.
    task automatic run_cmd(input logic [1:0] c_op, input logic [2:0] c_rd, input logic [2:0] c_rn,
                           input logic [7:0] c_imm, input bit noise);
        int busy, writes, exp_busy, exp_writes;
        logic [15:0] t;
        check("idle_before_cmd", {31'h0, w}, 32'h1);
        s = 1'b1; op = c_op; rd = c_rd; rn = c_rn; imm8 = c_imm;
        @(negedge clk);
        busy = 0;
        writes = 0;
        while (w !== 1'b1 && busy < 20) begin
            busy++;
            if (write === 1'b1) writes++;
            if (noise) begin
                s    = 1'($urandom_range(0, 1));
                op   = 2'($urandom_range(0, 3));
                rd   = 3'($urandom_range(0, 7));
                rn   = 3'($urandom_range(0, 7));
                imm8 = 8'($urandom_range(0, 255));
            end else begin
                s = 1'b0;
            end
            @(negedge clk);
        end
        s = 1'b0;

        case (c_op)
            2'b00: begin m[c_rd] = 16'($signed(c_imm)); exp_busy = 1; exp_writes = 1; end
            2'b01: begin m[c_rd] = m[c_rn];             exp_busy = 2; exp_writes = 1; end
            2'b10: begin
                t = m[c_rd]; m[c_rd] = m[c_rn]; m[c_rn] = t;
                exp_busy = 4; exp_writes = 2;
            end
            default: begin m_result = m[c_rn];          exp_busy = 1; exp_writes = 0; end
        endcase

        check($sformatf("busy_op%0d", c_op), busy, exp_busy);
        check($sformatf("writes_op%0d", c_op), writes, exp_writes);
        check("write_low_when_idle", {31'h0, write}, 32'h0);
        check("result", {16'h0, result}, {16'h0, m_result});
        check_regs($sformatf("regs_op%0d", c_op));
    endtask

    initial begin
        int busy;
        reset = 1'b1; s = 1'b0; op = '0; rd = '0; rn = '0; imm8 = '0; bk_we = 1'b0;
        bk_idx = '0; bk_val = '0; m_result = '0;
        @(negedge clk);
        reset = 1'b0;

        check("rst_w", {31'h0, w}, 32'h1);
        check("rst_write", {31'h0, write}, 32'h0);
        check("rst_readnum", {29'h0, readnum}, 32'h0);
        check("rst_writenum", {29'h0, writenum}, 32'h0);
        check("rst_data_in", {16'h0, data_in}, 32'h0);
        check("rst_result", {16'h0, result}, 32'h0);

        for (int i = 0; i < 8; i++) poke(3'(i), 16'($urandom));

        // MOVI with sign extension, then immediate back-to-back PEEK.
        run_cmd(2'b00, 3'd3, 3'd0, 8'h85, 1'b0);
        run_cmd(2'b11, 3'd0, 3'd3, 8'h00, 1'b0);
        check("peek_r3_const", {16'h0, result}, 32'h0000_FF85);

        // MOV R5, R1.
        run_cmd(2'b00, 3'd1, 3'd0, 8'h12, 1'b0);
        run_cmd(2'b01, 3'd5, 3'd1, 8'h00, 1'b0);
        check("mov_r5_const", {16'h0, rf[5]}, 32'h0000_0012);

        // SWAP R2, R4.
        poke(3'd2, 16'h0007);
        poke(3'd4, 16'hFFF0);
        run_cmd(2'b10, 3'd2, 3'd4, 8'h00, 1'b0);
        check("swap_r2_const", {16'h0, rf[2]}, 32'h0000_FFF0);
        check("swap_r4_const", {16'h0, rf[4]}, 32'h0000_0007);

        // SWAP and MOV with rd == rn, with s pulsed while busy.
        poke(3'd6, 16'h00AA);
        run_cmd(2'b10, 3'd6, 3'd6, 8'h00, 1'b1);
        check("swap_self_const", {16'h0, rf[6]}, 32'h0000_00AA);
        run_cmd(2'b01, 3'd6, 3'd6, 8'h00, 1'b1);

        // Sign extension boundaries.
        run_cmd(2'b00, 3'd0, 3'd0, 8'h80, 1'b0);
        check("movi_80", {16'h0, rf[0]}, 32'h0000_FF80);
        run_cmd(2'b00, 3'd7, 3'd0, 8'h7F, 1'b0);
        check("movi_7f", {16'h0, rf[7]}, 32'h0000_007F);

        // Reset during RD_B of a SWAP aborts it with no writes.
        poke(3'd2, 16'h0007);
        poke(3'd4, 16'hFFF0);
        s = 1'b1; op = 2'b10; rd = 3'd2; rn = 3'd4;
        @(negedge clk);
        s = 1'b0;
        check("abort_rd_a_write", {31'h0, write}, 32'h0);
        @(negedge clk);
        check("abort_rd_b_write", {31'h0, write}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_result = '0;
        check("abort_w", {31'h0, w}, 32'h1);
        check("abort_write", {31'h0, write}, 32'h0);
        check("abort_readnum", {29'h0, readnum}, 32'h0);
        check("abort_writenum", {29'h0, writenum}, 32'h0);
        check("abort_result", {16'h0, result}, 32'h0);
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            if (write === 1'b1) busy++;
            @(negedge clk);
        end
        check("abort_no_write_after", busy, 0);
        check_regs("abort");

        // Randomized command stream.
        for (int i = 0; i < 40; i++)
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
